// File: rtl/transposed_fir_param_if.sv
// Sample/coefficient/result bundle for transposed_fir_param.
// master drives samples and coefficient writes; slave is the filter.
interface transposed_fir_param_if #(
    parameter int DATA_W  = 3,
    parameter int COEFF_W = 16,
    parameter int OUT_W   = 16,
    parameter int AW      = 4
);
    logic                      en_sample;
    logic signed [DATA_W-1:0]  fir_in;
    logic                      clear;
    logic                      coeff_wr;
    logic [AW-1:0]             coeff_addr;
    logic signed [COEFF_W-1:0] coeff_data;
    logic                      coeff_commit;
    logic                      commit_pend;
    logic signed [OUT_W-1:0]   fir_out;
    logic                      valid;
    logic                      sat;
    logic                      primed;

    modport master (
        output en_sample, fir_in, clear, coeff_wr, coeff_addr, coeff_data, coeff_commit,
        input  commit_pend, fir_out, valid, sat, primed
    );

    modport slave (
        input  en_sample, fir_in, clear, coeff_wr, coeff_addr, coeff_data, coeff_commit,
        output commit_pend, fir_out, valid, sat, primed
    );
endinterface

// File: rtl/transposed_fir_param.sv
// Transposed-form FIR with double-buffered coefficients, rounding shift and saturation.
// Latency 1 clk from strobe to valid; one sample per clk, no back-pressure.
module transposed_fir_param #(
    parameter int  NUM_TAPS = 10,
    parameter int  DATA_W   = 3,
    parameter int  COEFF_W  = 16,
    parameter int  OUT_W    = 16,
    parameter int  SHIFT    = 0,
    localparam int ACC_W    = DATA_W + COEFF_W + $clog2(NUM_TAPS),
    localparam int AW       = $clog2(NUM_TAPS)
) (
    input logic                  clk,
    input logic                  rst_n,
    transposed_fir_param_if.slave bus
);
    localparam int CNT_W = $clog2(NUM_TAPS + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(NUM_TAPS);
    localparam logic [AW:0]      NT_ADDR  = (AW + 1)'(NUM_TAPS);
    localparam logic signed [ACC_W:0] MAXV = (ACC_W + 1)'(2 ** (OUT_W - 1) - 1);
    localparam logic signed [ACC_W:0] MINV = ~MAXV;

    logic signed [COEFF_W-1:0] shadow [NUM_TAPS];
    logic signed [COEFF_W-1:0] active [NUM_TAPS];
    logic signed [COEFF_W-1:0] coef   [NUM_TAPS];
    logic signed [ACC_W-1:0]   prod   [NUM_TAPS];
    logic signed [ACC_W-1:0]   z      [1:NUM_TAPS-1];
    logic signed [ACC_W-1:0]   x_ext;
    logic signed [ACC_W-1:0]   acc;
    logic signed [ACC_W:0]     acc_ext;
    logic signed [ACC_W:0]     r;
    logic signed [OUT_W-1:0]   sat_val;
    logic                      sat_flag;
    logic                      accept;
    logic                      copy;
    logic                      pend;
    logic [CNT_W-1:0]          cnt;
    logic signed [OUT_W-1:0]   out_q;
    logic                      valid_q;
    logic                      sat_q;
    logic                      primed_q;

    // Clear outranks a coincident strobe: the sample is dropped and no copy happens.
    assign accept = bus.en_sample & ~bus.clear;
    assign copy   = accept & pend;
    assign x_ext  = {{(ACC_W - DATA_W){bus.fir_in[DATA_W-1]}}, bus.fir_in};

    // While a commit is pending the shadow bank feeds the multipliers, so the
    // sample that triggers the copy already sees the new coefficients.
    always_comb begin
        for (int k = 0; k < NUM_TAPS; k++) begin
            coef[k] = pend ? shadow[k] : active[k];
            prod[k] = x_ext * {{(ACC_W - COEFF_W){coef[k][COEFF_W-1]}}, coef[k]};
        end
    end

    assign acc     = prod[0] + z[1];
    assign acc_ext = {acc[ACC_W-1], acc};

    generate
        if (SHIFT > 0) begin : g_round
            localparam logic signed [ACC_W:0] HALF = (ACC_W + 1)'(2 ** (SHIFT - 1));
            assign r = (acc_ext + HALF) >>> SHIFT;
        end else begin : g_noround
            assign r = acc_ext;
        end
    endgenerate

    always_comb begin
        sat_val  = r[OUT_W-1:0];
        sat_flag = 1'b0;
        if (r > MAXV) begin
            sat_val  = MAXV[OUT_W-1:0];
            sat_flag = 1'b1;
        end else if (r < MINV) begin
            sat_val  = MINV[OUT_W-1:0];
            sat_flag = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_TAPS; k++) begin
                shadow[k] <= '0;
                active[k] <= '0;
            end
            pend <= 1'b0;
        end else begin
            if (bus.coeff_wr && ({1'b0, bus.coeff_addr} < NT_ADDR))
                shadow[bus.coeff_addr] <= bus.coeff_data;
            if (copy) begin
                for (int k = 0; k < NUM_TAPS; k++) active[k] <= shadow[k];
                pend <= 1'b0;
            end else if (bus.coeff_commit) begin
                pend <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 1; k < NUM_TAPS; k++) z[k] <= '0;
            cnt      <= '0;
            primed_q <= 1'b0;
            out_q    <= '0;
            sat_q    <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            valid_q <= accept;
            if (bus.clear) begin
                for (int k = 1; k < NUM_TAPS; k++) z[k] <= '0;
                cnt      <= '0;
                primed_q <= 1'b0;
            end else if (bus.en_sample) begin
                for (int k = 1; k < NUM_TAPS - 1; k++) z[k] <= z[k+1] + prod[k];
                z[NUM_TAPS-1] <= prod[NUM_TAPS-1];
                out_q <= sat_val;
                sat_q <= sat_flag;
                if (cnt != FULL_CNT) cnt <= cnt + 1'b1;
                primed_q <= primed_q | (cnt == FULL_CNT - 1'b1);
            end
        end
    end

    assign bus.commit_pend = pend;
    assign bus.fir_out     = out_q;
    assign bus.valid       = valid_q;
    assign bus.sat         = sat_q;
    assign bus.primed      = primed_q;
endmodule

// File: tb/tb_transposed_fir_param.sv
// Directed bench: two filters (SHIFT 0 and 2) share one stimulus stream;
// expected values are hand-derived or from a direct-form convolution.
module tb_transposed_fir_param;
    localparam int NT = 10;
    localparam int DW = 3;
    localparam int CW = 16;
    localparam int OW = 16;
    localparam int AW = 4;
    localparam int NS = 24;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic                 en_sample    = 1'b0;
    logic                 clear        = 1'b0;
    logic                 coeff_wr     = 1'b0;
    logic                 coeff_commit = 1'b0;
    logic signed [DW-1:0] fir_in       = '0;
    logic [AW-1:0]        coeff_addr   = '0;
    logic signed [CW-1:0] coeff_data   = '0;

    transposed_fir_param_if #(.DATA_W(DW), .COEFF_W(CW), .OUT_W(OW), .AW(AW)) ia ();
    transposed_fir_param_if #(.DATA_W(DW), .COEFF_W(CW), .OUT_W(OW), .AW(AW)) ib ();

    assign ia.en_sample = en_sample;    assign ib.en_sample = en_sample;
    assign ia.fir_in = fir_in;          assign ib.fir_in = fir_in;
    assign ia.clear = clear;            assign ib.clear = clear;
    assign ia.coeff_wr = coeff_wr;      assign ib.coeff_wr = coeff_wr;
    assign ia.coeff_addr = coeff_addr;  assign ib.coeff_addr = coeff_addr;
    assign ia.coeff_data = coeff_data;  assign ib.coeff_data = coeff_data;
    assign ia.coeff_commit = coeff_commit;
    assign ib.coeff_commit = coeff_commit;

    transposed_fir_param #(.NUM_TAPS(NT), .DATA_W(DW), .COEFF_W(CW), .OUT_W(OW), .SHIFT(0))
        dut_a (.clk(clk), .rst_n(rst_n), .bus(ia.slave));
    transposed_fir_param #(.NUM_TAPS(NT), .DATA_W(DW), .COEFF_W(CW), .OUT_W(OW), .SHIFT(2))
        dut_b (.clk(clk), .rst_n(rst_n), .bus(ib.slave));

    int checks = 0;
    int passed = 0;

    task automatic chk(input string tag, input longint got, input longint exp);
        checks++;
        if (got == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr(input int a, input int d);
        @(negedge clk);
        coeff_wr = 1'b1; coeff_addr = AW'(a); coeff_data = CW'(d);
        @(negedge clk);
        coeff_wr = 1'b0;
    endtask

    task automatic commit();
        @(negedge clk); coeff_commit = 1'b1;
        @(negedge clk); coeff_commit = 1'b0;
    endtask

    // Returns on the negedge after the strobe edge, where valid/fir_out are visible.
    task automatic strobe(input int x, input bit cm, input bit cl);
        @(negedge clk);
        en_sample = 1'b1; fir_in = DW'(x); coeff_commit = cm; clear = cl;
        @(negedge clk);
        en_sample = 1'b0; coeff_commit = 1'b0; clear = 1'b0;
    endtask

    function automatic longint scaled(input longint acc, input int sh);
        longint r;
        r = (sh > 0) ? ((acc + (longint'(1) <<< (sh - 1))) >>> sh) : acc;
        if (r > 32767) return 32767;
        if (r < -32768) return -32768;
        return r;
    endfunction

    function automatic longint sat_of(input longint acc, input int sh);
        longint r;
        r = (sh > 0) ? ((acc + (longint'(1) <<< (sh - 1))) >>> sh) : acc;
        return (r > 32767 || r < -32768) ? 1 : 0;
    endfunction

    int     c  [NT];
    int     xs [NS];
    longint ref_acc [NS];

    initial begin
        // Reset state
        cyc(3);
        chk("rst_out", ia.fir_out, 0);
        chk("rst_valid", ia.valid, 0);
        chk("rst_sat", ia.sat, 0);
        chk("rst_primed", ia.primed, 0);
        chk("rst_pend", ia.commit_pend, 0);
        rst_n = 1'b1;

        // Impulse response with coefficients 1..10
        for (int k = 0; k < NT; k++) wr(k, k + 1);
        commit();
        chk("imp_pend_set", ia.commit_pend, 1);
        for (int n = 0; n <= NT; n++) begin
            strobe((n == 0) ? 1 : 0, 1'b0, 1'b0);
            chk($sformatf("imp_out%0d", n), ia.fir_out, (n < NT) ? n + 1 : 0);
            chk($sformatf("imp_valid%0d", n), ia.valid, 1);
            chk($sformatf("imp_primed%0d", n), ia.primed, (n >= NT - 1) ? 1 : 0);
            if (n == 0) chk("imp_pend_clr", ia.commit_pend, 0);
            cyc(1);
            if (n == 0) chk("imp_valid_pulse", ia.valid, 0);
            cyc(6);
        end

        // Saturation both ways, then recovery
        for (int k = 0; k < NT; k++) wr(k, 32767);
        commit();
        for (int n = 0; n < NT; n++) strobe(-4, 1'b0, 1'b0);
        chk("sat_neg_out", ia.fir_out, -32768);
        chk("sat_neg_flag", ia.sat, 1);
        cyc(4);
        chk("sat_hold_out", ia.fir_out, -32768);
        chk("sat_hold_flag", ia.sat, 1);
        chk("sat_hold_valid", ia.valid, 0);
        for (int n = 0; n < NT; n++) strobe(3, 1'b0, 1'b0);
        chk("sat_pos_out", ia.fir_out, 32767);
        chk("sat_pos_flag", ia.sat, 1);
        for (int n = 0; n < NT; n++) strobe(0, 1'b0, 1'b0);
        chk("sat_zero_out", ia.fir_out, 0);
        chk("sat_zero_flag", ia.sat, 0);

        // Rounding on the SHIFT=2 instance
        wr(0, 6);
        for (int k = 1; k < NT; k++) wr(k, 0);
        commit();
        strobe(1, 1'b0, 1'b0);
        chk("rnd_pos_b", ib.fir_out, 2);
        chk("rnd_pos_a", ia.fir_out, 6);
        strobe(-1, 1'b0, 1'b0);
        chk("rnd_neg_b", ib.fir_out, -1);
        chk("rnd_neg_a", ia.fir_out, -6);

        // Commit coincident with a strobe uses old coefficients
        wr(0, 1);
        commit();
        strobe(0, 1'b0, 1'b0);
        wr(0, 5);
        strobe(1, 1'b1, 1'b0);
        chk("cmt_old_out", ia.fir_out, 1);
        chk("cmt_pend", ia.commit_pend, 1);
        strobe(1, 1'b0, 1'b0);
        chk("cmt_new_out", ia.fir_out, 5);
        chk("cmt_pend_clr", ia.commit_pend, 0);

        // Clear mid-stream, then a clean impulse
        for (int k = 0; k < NT; k++) wr(k, k + 1);
        commit();
        strobe(1, 1'b0, 1'b0);
        chk("clr_pre1", ia.fir_out, 1);
        strobe(0, 1'b0, 1'b0);
        chk("clr_pre2", ia.fir_out, 2);
        chk("clr_pre_primed", ia.primed, 1);
        strobe(3, 1'b0, 1'b1);
        chk("clr_valid", ia.valid, 0);
        chk("clr_hold_out", ia.fir_out, 2);
        chk("clr_primed", ia.primed, 0);
        for (int n = 0; n < NT; n++) begin
            strobe((n == 0) ? 1 : 0, 1'b0, 1'b0);
            chk($sformatf("clr_imp%0d", n), ia.fir_out, n + 1);
            if (n >= NT - 2) chk($sformatf("clr_primed%0d", n), ia.primed, (n == NT - 1) ? 1 : 0);
        end

        // Reset mid-stream wipes both banks
        strobe(1, 1'b0, 1'b0);
        chk("rst2_pre", ia.fir_out, 1);
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk);
        chk("rst2_out", ia.fir_out, 0);
        chk("rst2_valid", ia.valid, 0);
        chk("rst2_primed", ia.primed, 0);
        chk("rst2_pend", ia.commit_pend, 0);
        rst_n = 1'b1;
        strobe(1, 1'b0, 1'b0);
        chk("rst2_zero_a", ia.fir_out, 0);
        commit();
        strobe(1, 1'b0, 1'b0);
        chk("rst2_zero_recommit", ia.fir_out, 0);

        // Back-to-back strobes against a direct-form convolution
        for (int k = 0; k < NT; k++) begin
            c[k] = int'($urandom_range(0, 65535)) - 32768;
            wr(k, c[k]);
        end
        for (int i = 0; i < NS; i++) xs[i] = int'($urandom_range(0, 7)) - 4;
        for (int i = 0; i < NS; i++) begin
            ref_acc[i] = 0;
            for (int k = 0; k < NT && k <= i; k++)
                ref_acc[i] += longint'(c[k]) * longint'(xs[i - k]);
        end
        commit();
        cyc(2);
        for (int i = 0; i <= NS; i++) begin
            @(negedge clk);
            if (i > 0) begin
                chk($sformatf("b2b_a%0d", i - 1), ia.fir_out, scaled(ref_acc[i - 1], 0));
                chk($sformatf("b2b_sat%0d", i - 1), ia.sat, sat_of(ref_acc[i - 1], 0));
                chk($sformatf("b2b_b%0d", i - 1), ib.fir_out, scaled(ref_acc[i - 1], 2));
                chk($sformatf("b2b_v%0d", i - 1), ia.valid, 1);
            end
            if (i < NS) begin
                en_sample = 1'b1;
                fir_in = DW'(xs[i]);
            end else begin
                en_sample = 1'b0;
            end
        end
        @(negedge clk);
        chk("b2b_valid_end", ia.valid, 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
